// File: rtl/conv_writeback.sv
// Result writeback for the 3x3 convolution engine: requantises each result pair,
// buffers it in a small FIFO and serialises the two SRAM writes under back-pressure.
// Optional build macro CONV_WB_RELU_EN: treat sums as signed and clamp negatives to zero.
module conv_writeback #(
  parameter int ACC_W      = 16,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [ACC_W-1:0]  i_sum1,
  input  logic [ACC_W-1:0]  i_sum2,
  input  logic [ADDR_W-1:0] i_dest_addr1,
  input  logic [ADDR_W-1:0] i_dest_addr2,
  input  logic [3:0]        i_shift,
  output logic              o_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  input  logic              i_wr_ready,
  output logic              o_busy,
  output logic              o_overflow,
  output logic [15:0]       o_pair_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR1  = 2'd1,
    WR2  = 2'd2
  } state_t;

  function automatic logic [7:0] requant(input logic [ACC_W-1:0] x, input logic [3:0] sh);
    logic [ACC_W-1:0] y;
`ifdef CONV_WB_RELU_EN
    logic signed [ACC_W-1:0] xs;
    xs = signed'(x);
    if (xs < 0) return 8'd0;
`endif
    y = x >> sh;
    if (y > ACC_W'(255)) return 8'hFF;
    return y[7:0];
  endfunction

  // Pair storage carries no reset; only the pointers and occupancy qualify it.
  logic [7:0]        data1_mem [FIFO_DEPTH];
  logic [7:0]        data2_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr1_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr2_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [PTR_W:0]    count_q, count_d;
  logic              ready_q, ready_d;
  logic              overflow_q;
  state_t            state_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [15:0]       pair_cnt_q;

  logic              push, pop;
  logic [7:0]        q1, q2;
  logic              nxt_avail;
  logic [ADDR_W-1:0] nxt_addr1;
  logic [7:0]        nxt_data1;

  assign q1   = requant(i_sum1, i_shift);
  assign q2   = requant(i_sum2, i_shift);
  assign push = i_valid & ready_q;
  assign pop  = (state_q == WR2) & i_wr_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    ready_d = (count_d != CNT_FULL);
  end

  // Next pair after the head retires: from storage, or bypassed from a same-edge push.
  always_comb begin
    rd_nxt    = rd_ptr_q + 1'b1;
    nxt_avail = (count_q > CNT_ONE) | push;
    nxt_addr1 = i_dest_addr1;
    nxt_data1 = q1;
    if (count_q > CNT_ONE) begin
      nxt_addr1 = addr1_mem[rd_nxt];
      nxt_data1 = data1_mem[rd_nxt];
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      data1_mem[wr_ptr_q] <= q1;
      data2_mem[wr_ptr_q] <= q2;
      addr1_mem[wr_ptr_q] <= i_dest_addr1;
      addr2_mem[wr_ptr_q] <= i_dest_addr2;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= ready_d;
      if (i_valid && !ready_q) overflow_q <= 1'b1;
    end
  end

  // Write sequencer: outputs only change on acceptance, so they hold under back-pressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      pair_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_q   <= WR1;
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr1_mem[rd_ptr_q];
            wr_data_q <= data1_mem[rd_ptr_q];
          end
        end
        WR1: begin
          if (i_wr_ready) begin
            state_q   <= WR2;
            wr_addr_q <= addr2_mem[rd_ptr_q];
            wr_data_q <= data2_mem[rd_ptr_q];
          end
        end
        WR2: begin
          if (i_wr_ready) begin
            pair_cnt_q <= pair_cnt_q + 16'd1;
            if (nxt_avail) begin
              state_q   <= WR1;
              wr_addr_q <= nxt_addr1;
              wr_data_q <= nxt_data1;
            end else begin
              state_q   <= IDLE;
              wr_en_q   <= 1'b0;
              wr_addr_q <= '0;
              wr_data_q <= '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready    = ready_q;
  assign o_wr_en    = wr_en_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_busy     = (count_q != '0);
  assign o_overflow = overflow_q;
  assign o_pair_cnt = pair_cnt_q;

endmodule

// File: tb/tb_conv_writeback.sv
// Directed bench for conv_writeback: expected SRAM writes are queued at stimulus time
// and matched in order against accepted writes observed on the falling edge.
module tb_conv_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_sum1 = '0, i_sum2 = '0;
  logic [9:0]  i_addr1 = '0, i_addr2 = '0;
  logic [3:0]  i_shift = '0;
  logic        o_ready, o_wr_en, i_wr_ready = 1'b1, o_busy, o_overflow;
  logic [9:0]  o_wr_addr;
  logic [7:0]  o_wr_data;
  logic [15:0] o_pair_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_pairs = 0;
  logic [17:0] exp_q[$];
  int          wr_cyc[$];

  conv_writeback #(.ACC_W(16), .ADDR_W(10), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid),
    .i_sum1(i_sum1), .i_sum2(i_sum2),
    .i_dest_addr1(i_addr1), .i_dest_addr2(i_addr2), .i_shift(i_shift),
    .o_ready(o_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .i_wr_ready(i_wr_ready), .o_busy(o_busy), .o_overflow(o_overflow), .o_pair_cnt(o_pair_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_q(input logic [15:0] x, input int sh);
    int v;
`ifdef CONV_WB_RELU_EN
    if (x[15]) return 8'h00;
`endif
    v = int'(x) / (1 << sh);
    if (v > 255) return 8'hFF;
    return v[7:0];
  endfunction

  // Accepted-write monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n && o_wr_en && i_wr_ready) begin
      wr_cyc.push_back(cyc);
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed=%0h/%0h expected=none", o_wr_addr, o_wr_data);
      end
      if (exp_q.size() != 0) chk("write", {14'd0, o_wr_addr, o_wr_data}, {14'd0, exp_q.pop_front()});
    end
  end

  task automatic send(input logic [15:0] s1, input logic [15:0] s2, input logic [9:0] a1,
                      input logic [9:0] a2, input logic [3:0] sh, input bit acc);
    @(posedge clk); #1;
    i_valid = 1'b1; i_sum1 = s1; i_sum2 = s2; i_addr1 = a1; i_addr2 = a2; i_shift = sh;
    if (acc) begin
      exp_q.push_back({a1, model_q(s1, int'(sh))});
      exp_q.push_back({a2, model_q(s2, int'(sh))});
      exp_pairs++;
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_busy !== 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 200), 32'd1);
    @(negedge clk);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_pair_cnt"}, o_pair_cnt, exp_pairs);
  endtask

  initial begin
    logic [9:0] ha;
    logic [7:0] hd;
    // Reset state
    #12;
    chk("rst_ready", o_ready, 1);
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_pair_cnt", o_pair_cnt, 0);
    @(negedge clk); rst_n = 1'b1;

    // Basic pair plus latency
    send(16'h0040, 16'h0300, 10'd5, 10'd6, 4'd2, 1'b1);
    @(negedge clk);
    chk("lat_no_wr_yet", o_wr_en, 0);
    chk("lat_busy", o_busy, 1);
    @(negedge clk);
    chk("lat_wr_en", o_wr_en, 1);
    wait_idle("basic");

    // Saturation and large shift; same-address pair
    send(16'h1234, 16'h1234, 10'd10, 10'd11, 4'd0, 1'b1);
    send(16'h1234, 16'h00FF, 10'd12, 10'd13, 4'd8, 1'b1);
    send(16'h0010, 16'h0020, 10'd9, 10'd9, 4'd0, 1'b1);
    wait_idle("sat");

    // Back-pressure during the second write of a pair
    send(16'h0077, 16'h0088, 10'd20, 10'd21, 4'd0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_wr_ready = 1'b0;
    @(negedge clk);
    ha = o_wr_addr; hd = o_wr_data;
    chk("bp_addr2", ha, 21);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {o_wr_en, o_wr_addr, o_wr_data}, {1'b1, ha, hd});
    end
    @(posedge clk); #1;
    i_wr_ready = 1'b1;
    wait_idle("bp");

    // Fill with SRAM stalled: fifth pair must be dropped
    i_wr_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(16'(16'h0100 + i), 16'(16'h0010 + i), 10'(100 + 2*i), 10'(101 + 2*i), 4'd1, 1'b1);
    chk("fill_ready_low", o_ready, 0);
    chk("fill_no_ovf_yet", o_overflow, 0);
    send(16'h0055, 16'h0066, 10'd200, 10'd201, 4'd0, 1'b0);
    chk("fill_overflow", o_overflow, 1);
    wr_cyc.delete();
    @(posedge clk); #1;
    i_wr_ready = 1'b1;
    wait_idle("fill");
    chk("fill_writes", wr_cyc.size(), 8);
    chk("fill_ready_back", o_ready, 1);
    chk("fill_ovf_sticky", o_overflow, 1);

    // Streaming, pairs two cycles apart: six writes with no bubble
    wr_cyc.delete();
    send(16'h0001, 16'h0002, 10'd300, 10'd301, 4'd0, 1'b1);
    send(16'h0003, 16'h0004, 10'd302, 10'd303, 4'd0, 1'b1);
    send(16'h0005, 16'h0006, 10'd304, 10'd305, 4'd0, 1'b1);
    wait_idle("stream2");
    chk("stream2_n", wr_cyc.size(), 6);
    if (wr_cyc.size() == 6) chk("stream2_span", wr_cyc[5] - wr_cyc[0], 5);

    // Streaming, three cycles apart: second pair follows the first with no gap
    wr_cyc.delete();
    send(16'h0011, 16'h0012, 10'd310, 10'd311, 4'd0, 1'b1);
    @(posedge clk);
    send(16'h0013, 16'h0014, 10'd312, 10'd313, 4'd0, 1'b1);
    @(posedge clk);
    send(16'h0015, 16'h0016, 10'd314, 10'd315, 4'd0, 1'b1);
    wait_idle("stream3");
    chk("stream3_n", wr_cyc.size(), 6);
    if (wr_cyc.size() == 6) begin
      chk("stream3_first4", wr_cyc[3] - wr_cyc[0], 3);
      chk("stream3_span", wr_cyc[5] - wr_cyc[0], 7);
    end

    // Negative-looking sums: clamp or saturate depending on build
    send(16'hFFF0, 16'h8000, 10'd400, 10'd401, 4'd8, 1'b1);
    wait_idle("sign");

    // Asynchronous reset while the first write is stalled
    i_wr_ready = 1'b0;
    send(16'h0042, 16'h0043, 10'd500, 10'd501, 4'd0, 1'b1);
    @(posedge clk); #1;
    chk("ar_wr_en_before", o_wr_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_wr_en", o_wr_en, 0);
    chk("ar_busy", o_busy, 0);
    chk("ar_ready", o_ready, 1);
    chk("ar_pair_cnt", o_pair_cnt, 0);
    chk("ar_overflow", o_overflow, 0);
    exp_q.delete();
    exp_pairs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    i_wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("ar_stays_idle", {o_wr_en, o_busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
